register_rename_table: RTL

- Parametrised rename stage for the out-of-order MIPS core. It replaces the identity-only architectural map with real renaming.
- Maps architectural source/destination registers to physical registers and allocates fresh physical destinations from a circular free list.
- Maintains a retirement map updated at commit, returns superseded registers to the free list, and restores the speculative map in one cycle on flush.
- Sits between decode and the issue/ROB stages.

---
 rtl/register_rename_table.sv | 118 +++++++++++
 1 files changed

// File: rtl/register_rename_table.sv
// Rename stage: speculative/retirement architectural-to-physical maps with a
// circular free list of physical registers and single-cycle flush recovery.
module register_rename_table #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  localparam int unsigned AW = $clog2(ARCH_REGS),
  localparam int unsigned PW = $clog2(PHYS_REGS),
  localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rn_valid,
  output logic          rn_ready,
  input  logic          uses_rs,
  input  logic          uses_rt,
  input  logic          uses_rw,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] rw_addr,
  output logic [PW-1:0] prs_addr,
  output logic [PW-1:0] prt_addr,
  output logic [PW-1:0] prw_addr,
  output logic [PW-1:0] old_prw_addr,
  input  logic          cm_valid,
  input  logic          cm_uses_rw,
  input  logic [AW-1:0] cm_rw_addr,
  input  logic [PW-1:0] cm_prw_addr,
  input  logic [PW-1:0] cm_old_prw_addr,
  input  logic          flush,
  output logic [PW:0]   free_count
);

  localparam int unsigned FW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] spec_map   [ARCH_REGS];
  logic [PW-1:0] retire_map [ARCH_REGS];
  logic [PW-1:0] retire_nxt [ARCH_REGS];
  logic [PW-1:0] storage    [FL_DEPTH];
  logic [FW-1:0] head;
  logic [FW-1:0] tail;
  logic [FW-1:0] tail_nxt;
  logic [CW-1:0] count;
  logic          alloc;
  logic          fire_alloc;
  logic          commit;

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == FW'(FL_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  // Handshake and lookups against the map held at the start of the cycle
  always_comb begin
    alloc        = uses_rw && (rw_addr != '0);
    commit       = cm_valid && cm_uses_rw && (cm_rw_addr != '0);
    rn_ready     = !flush && ((count != '0) || !alloc);
    fire_alloc   = rn_valid && rn_ready && alloc;
    prs_addr     = uses_rs ? spec_map[rs_addr] : '0;
    prt_addr     = uses_rt ? spec_map[rt_addr] : '0;
    old_prw_addr = alloc ? spec_map[rw_addr] : '0;
    prw_addr     = alloc ? storage[head] : '0;
    tail_nxt     = commit ? ptr_inc(tail) : tail;
  end

  // Retirement map with this cycle's commit applied; also the flush source
  always_comb begin
    retire_nxt = retire_map;
    if (commit) retire_nxt[cm_rw_addr] = cm_prw_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_map[i]   <= PW'(i);
        retire_map[i] <= PW'(i);
      end
    end else begin
      retire_map <= retire_nxt;
      if (flush)           spec_map <= retire_nxt;
      else if (fire_alloc) spec_map[rw_addr] <= storage[head];
    end
  end

  // Free list: entries from tail up to head still hold in-flight registers,
  // so pulling head back to tail on flush recycles them in allocation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < FL_DEPTH; k++) storage[k] <= PW'(ARCH_REGS + k);
    end else if (commit) begin
      storage[tail] <= cm_old_prw_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= CW'(FL_DEPTH);
    end else begin
      tail <= tail_nxt;
      if (flush) begin
        head  <= tail_nxt;
        count <= CW'(FL_DEPTH);
      end else begin
        if (fire_alloc) head <= ptr_inc(head);
        if (fire_alloc && !commit)      count <= count - CW'(1);
        else if (commit && !fire_alloc) count <= count + CW'(1);
      end
    end
  end

  assign free_count = count;

  no_commit_when_all_free: assert property (@(posedge clk) disable iff (!rst_n)
    !(commit && (count == CW'(FL_DEPTH))))
    else $error("register_rename_table: commit while every register is free");

endmodule
